// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifu_pkg                                                    |
// | Purpose : Shared types and constants for the instruction fetch unit. |
// |           FSM state encoding and the instruction word width.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ifu_pkg;

   localparam int INS_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifu_if                                                     |
// | Purpose : Bundles the host, instruction-memory and decode signals of |
// |           the fetch unit.                                            |
// | Modports: master - the fetch unit (drives busy/done, req/addr,       |
// |                    vld/ins, perf counter)                            |
// |           slave  - the environment (host, SRAM, decode)              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface ifu_if
   import ifu_pkg::*;
#(
   parameter int AW = 16
) ();

   logic             host_ifu_start;
   logic [AW-1:0]    host_ifu_pc;
   logic             ifu_host_busy;
   logic             ifu_host_done;
   logic             ifu_imem_req;
   logic [AW-1:0]    ifu_imem_addr;
   logic             imem_ifu_rvld;
   logic [INS_W-1:0] imem_ifu_rdata;
   logic             ifu_idu_vld;
   logic [INS_W-1:0] ifu_idu_ins;
   logic             idu_ifu_rdy;
   logic             idu_ifu_wfi;
   logic [31:0]      ifu_perf_cnt;

   modport master (
      input  host_ifu_start, host_ifu_pc, imem_ifu_rvld, imem_ifu_rdata,
             idu_ifu_rdy, idu_ifu_wfi,
      output ifu_host_busy, ifu_host_done, ifu_imem_req, ifu_imem_addr,
             ifu_idu_vld, ifu_idu_ins, ifu_perf_cnt
   );

   modport slave (
      output host_ifu_start, host_ifu_pc, imem_ifu_rvld, imem_ifu_rdata,
             idu_ifu_rdy, idu_ifu_wfi,
      input  ifu_host_busy, ifu_host_done, ifu_imem_req, ifu_imem_addr,
             ifu_idu_vld, ifu_idu_ins, ifu_perf_cnt
   );

endinterface
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifu_fifo                                                   |
// | Purpose : Synchronous prefetch FIFO with flush, no write-to-read     |
// |           bypass.                                                    |
// | Ports   : clk, rst_n       clock, async active-low reset             |
// |           flush_i          empty the FIFO at the next edge (wins)    |
// |           wr_i, wdata_i    push                                      |
// |           rd_i             pop (ignored when empty)                  |
// |           rdata_o          head entry                                |
// |           empty_o, cnt_o   status                                    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ifu_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     wr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     rd_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [PW:0]      cnt_q;
   logic             w_full;
   logic             w_rd;
   logic             w_wr;

   assign empty_o = (cnt_q == '0);
   assign w_full  = (cnt_q == (PW+1)'(DEPTH));
   assign w_rd    = rd_i & ~empty_o;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_wr    = wr_i & (~w_full | w_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (w_wr) wptr_q <= wptr_q + 1'b1;
         if (w_rd) rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + (PW+1)'(w_wr) - (PW+1)'(w_rd);
      end
   end

   // Storage needs no reset: an entry is only visible once counted.
   always_ff @(posedge clk) begin
      if (w_wr && !flush_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifu                                                        |
// | Purpose : Instruction fetch unit. Fetches 64-bit words from the      |
// |           instruction SRAM under a credit limit, buffers them in a   |
// |           prefetch FIFO and hands them to decode. Stops on WFI,      |
// |           dropping everything fetched past it.                       |
// | Ports   : clk, rst_n   clock, async active-low reset                 |
// |           bus          ifu_if.master (host, imem, decode, perf)      |
// | Macro   : IFU_PERF_CNT_EN - enables the saturating delivered-        |
// |           instruction counter on ifu_perf_cnt (else tied to 0).      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ifu
   import ifu_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   ifu_if.master  bus
);

   localparam int OW = $clog2(DEPTH) + 1;

   ifu_state_e       state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [OW-1:0]    outst_q, outst_d;
   logic [OW-1:0]    w_fifo_cnt;
   logic             w_fifo_empty;
   logic [INS_W-1:0] w_head;
   logic             w_fetch;
   logic             w_credit;
   logic             w_req;
   logic             w_rvld_acc;
   logic             w_wr;
   logic             w_flush;
   logic             w_vld;
   logic             w_rd;
   logic             w_done;

   assign w_fetch    = (state_q == ST_FETCH);
   // Buffered plus in-flight words may never exceed the FIFO size.
   assign w_credit   = ({1'b0, w_fifo_cnt} + {1'b0, outst_q}) < (OW+1)'(DEPTH);
   assign w_req      = w_fetch & ~bus.idu_ifu_wfi & w_credit;
   // Responses with nothing outstanding (e.g. issued before a reset) are dropped.
   assign w_rvld_acc = bus.imem_ifu_rvld & (outst_q != '0);
   assign w_wr       = w_rvld_acc & w_fetch & ~bus.idu_ifu_wfi;
   assign w_flush    = ~w_fetch | bus.idu_ifu_wfi;
   assign w_vld      = ~w_fifo_empty & w_fetch & ~bus.idu_ifu_wfi;
   assign w_rd       = w_vld & bus.idu_ifu_rdy;

   ifu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INS_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (w_flush),
      .wr_i    (w_wr),
      .wdata_i (bus.imem_ifu_rdata),
      .rd_i    (w_rd),
      .rdata_o (w_head),
      .empty_o (w_fifo_empty),
      .cnt_o   (w_fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      w_done  = 1'b0;
      outst_d = outst_q + OW'(w_req) - OW'(w_rvld_acc);
      case (state_q)
         ST_IDLE: begin
            if (bus.host_ifu_start) begin
               pc_d    = bus.host_ifu_pc;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (w_req) pc_d = pc_q + 1'b1;
            if (bus.idu_ifu_wfi) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((outst_q == '0) && !bus.idu_ifu_wfi) begin
               state_d = ST_IDLE;
               w_done  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.ifu_host_busy = (state_q == ST_FETCH) | (state_q == ST_DRAIN);
   assign bus.ifu_host_done = w_done;
   assign bus.ifu_imem_req  = w_req;
   assign bus.ifu_imem_addr = pc_q;
   assign bus.ifu_idu_vld   = w_vld;
   assign bus.ifu_idu_ins   = w_vld ? w_head : '0;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if ((state_q == ST_IDLE) && bus.host_ifu_start) begin
         perf_q <= '0;
      end else if (w_rd && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign bus.ifu_perf_cnt = perf_q;
`else
   assign bus.ifu_perf_cnt = '0;
`endif

   a_rvld_orphan: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.imem_ifu_rvld && (outst_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ifu                                                     |
// | Purpose : Self-checking bench for ifu: SRAM and decode models, a     |
// |           reference model in the monitor and an expected-instruction |
// |           scoreboard.                                                |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ifu;
   import ifu_pkg::*;

   localparam int AW    = 16;
   localparam int DEPTH = 2;

   typedef struct {
      int          due;
      logic [15:0] addr;
   } rsp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifu_if #(.AW(AW)) bus_if ();

   ifu #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          mem_lat = 1;
   int          cyc = 0;
   logic [63:0] exp_q [$];
   rsp_t        pend_q [$];

   function automatic logic [63:0] mem_word(input logic [15:0] a);
      return {16'hA5A5, a, 16'h5A5A, ~a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction SRAM: in-order responses a fixed number of cycles after req.
   initial begin
      rsp_t r;
      bus_if.imem_ifu_rvld  = 1'b0;
      bus_if.imem_ifu_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus_if.ifu_imem_req === 1'b1)
            pend_q.push_back('{cyc + mem_lat, bus_if.ifu_imem_addr});
         @(posedge clk);
         #1;
         cyc++;
         if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            r = pend_q.pop_front();
            bus_if.imem_ifu_rvld  = 1'b1;
            bus_if.imem_ifu_rdata = mem_word(r.addr);
         end else begin
            bus_if.imem_ifu_rvld  = 1'b0;
            bus_if.imem_ifu_rdata = '0;
         end
      end
   end

   // Monitor: reference model of the fetch unit plus instruction scoreboard.
   initial begin
      ifu_state_e  m_state;
      int          m_infl;
      int          m_held;
      logic [15:0] m_pc;
      logic [31:0] m_perf;
      logic        e_req, e_vld, e_done, rvacc, hs, wr;
      logic [63:0] e_ins;
      m_state = ST_IDLE; m_infl = 0; m_held = 0; m_pc = '0; m_perf = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_state = ST_IDLE; m_infl = 0; m_held = 0; m_pc = '0; m_perf = '0;
            continue;
         end
         e_req  = (m_state == ST_FETCH) && !bus_if.idu_ifu_wfi && (m_infl + m_held < DEPTH);
         e_vld  = (m_held > 0) && (m_state == ST_FETCH) && !bus_if.idu_ifu_wfi;
         e_done = (m_state == ST_DRAIN) && (m_infl == 0) && !bus_if.idu_ifu_wfi;
         chk("req", 64'(bus_if.ifu_imem_req), 64'(e_req));
         if (e_req) chk("addr", 64'(bus_if.ifu_imem_addr), 64'(m_pc));
         chk("vld", 64'(bus_if.ifu_idu_vld), 64'(e_vld));
         if (e_vld && bus_if.idu_ifu_rdy) begin
            e_ins = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            chk("ins", bus_if.ifu_idu_ins, e_ins);
         end
         chk("busy", 64'(bus_if.ifu_host_busy), 64'(m_state != ST_IDLE));
         chk("done", 64'(bus_if.ifu_host_done), 64'(e_done));
`ifdef IFU_PERF_CNT_EN
         chk("perf", 64'(bus_if.ifu_perf_cnt), 64'(m_perf));
`else
         chk("perf", 64'(bus_if.ifu_perf_cnt), 64'd0);
`endif
         rvacc  = bus_if.imem_ifu_rvld && (m_infl > 0);
         hs     = e_vld && bus_if.idu_ifu_rdy;
         wr     = rvacc && (m_state == ST_FETCH) && !bus_if.idu_ifu_wfi;
         m_infl = m_infl + int'(e_req) - int'(rvacc);
         if ((m_state != ST_FETCH) || bus_if.idu_ifu_wfi) m_held = 0;
         else m_held = m_held + int'(wr) - int'(hs);
         if (hs && (m_perf != 32'hFFFF_FFFF)) m_perf = m_perf + 32'd1;
         case (m_state)
            ST_IDLE: if (bus_if.host_ifu_start) begin
               m_state = ST_FETCH; m_pc = bus_if.host_ifu_pc; m_perf = '0;
            end
            ST_FETCH: begin
               if (e_req) m_pc = m_pc + 16'd1;
               if (bus_if.idu_ifu_wfi) m_state = ST_DRAIN;
            end
            ST_DRAIN: if (e_done) m_state = ST_IDLE;
            default: m_state = ST_IDLE;
         endcase
      end
   end

   task automatic reset_chk();
      chk("rst_req",  64'(bus_if.ifu_imem_req),  64'd0);
      chk("rst_addr", 64'(bus_if.ifu_imem_addr), 64'd0);
      chk("rst_vld",  64'(bus_if.ifu_idu_vld),   64'd0);
      chk("rst_ins",  bus_if.ifu_idu_ins,        64'd0);
      chk("rst_busy", 64'(bus_if.ifu_host_busy), 64'd0);
      chk("rst_done", 64'(bus_if.ifu_host_done), 64'd0);
      chk("rst_perf", 64'(bus_if.ifu_perf_cnt),  64'd0);
   endtask

   // Decode model: accept n instructions (rdy low during the stall window),
   // then report the last one as a WFI for three cycles and wait for idle.
   task automatic run(input logic [15:0] pc, input int lat, input int n,
                      input int st_at, input int st_len);
      int cnt = 0;
      int k   = 0;
      int tmo = 0;
      mem_lat = lat;
      @(posedge clk); #1;
      bus_if.host_ifu_start = 1'b1;
      bus_if.host_ifu_pc    = pc;
      bus_if.idu_ifu_rdy    = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus_if.host_ifu_start = 1'b0;
      while (cnt < n && tmo < 300) begin
         bus_if.idu_ifu_rdy = !(k >= st_at && k < st_at + st_len);
         @(negedge clk);
         if (bus_if.ifu_idu_vld && bus_if.idu_ifu_rdy) cnt++;
         @(posedge clk); #1;
         k++;
         tmo++;
      end
      chk("deliver_cnt", 64'(cnt), 64'(n));
      bus_if.idu_ifu_wfi = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      bus_if.idu_ifu_wfi = 1'b0;
      tmo = 0;
      while (bus_if.ifu_host_busy && tmo < 50) begin
         @(posedge clk); #1;
         tmo++;
      end
      chk("drain_idle", 64'(bus_if.ifu_host_busy), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      bus_if.host_ifu_start = 1'b0;
      bus_if.host_ifu_pc    = '0;
      bus_if.idu_ifu_rdy    = 1'b0;
      bus_if.idu_ifu_wfi    = 1'b0;
      @(posedge clk); #2;
      reset_chk();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic fetch, latency 1
      exp_q.push_back(64'hA5A5_0010_5A5A_FFEF);
      exp_q.push_back(64'hA5A5_0011_5A5A_FFEE);
      exp_q.push_back(64'hA5A5_0012_5A5A_FFED);
      exp_q.push_back(64'hA5A5_0013_5A5A_FFEC);
      run(16'h0010, 1, 4, -1, 0);

      // Decode back-pressure for 5 cycles
      exp_q.push_back(64'hA5A5_0040_5A5A_FFBF);
      exp_q.push_back(64'hA5A5_0041_5A5A_FFBE);
      exp_q.push_back(64'hA5A5_0042_5A5A_FFBD);
      exp_q.push_back(64'hA5A5_0043_5A5A_FFBC);
      exp_q.push_back(64'hA5A5_0044_5A5A_FFBB);
      run(16'h0040, 1, 5, 3, 5);

      // Memory latency 3
      exp_q.push_back(64'hA5A5_0080_5A5A_FF7F);
      exp_q.push_back(64'hA5A5_0081_5A5A_FF7E);
      exp_q.push_back(64'hA5A5_0082_5A5A_FF7D);
      exp_q.push_back(64'hA5A5_0083_5A5A_FF7C);
      run(16'h0080, 3, 4, -1, 0);

      // WFI at 0x12 with later words in flight (latency 2)
      exp_q.push_back(64'hA5A5_0010_5A5A_FFEF);
      exp_q.push_back(64'hA5A5_0011_5A5A_FFEE);
      exp_q.push_back(64'hA5A5_0012_5A5A_FFED);
      run(16'h0010, 2, 3, -1, 0);

      // Address wrap
      exp_q.push_back(64'hA5A5_FFFF_5A5A_0000);
      exp_q.push_back(64'hA5A5_0000_5A5A_FFFF);
      exp_q.push_back(64'hA5A5_0001_5A5A_FFFE);
      run(16'hFFFF, 1, 3, -1, 0);

      // Reset while fetching with words outstanding; late responses land in reset
      mem_lat = 3;
      @(posedge clk); #1;
      bus_if.host_ifu_start = 1'b1;
      bus_if.host_ifu_pc    = 16'h0020;
      bus_if.idu_ifu_rdy    = 1'b1;
      @(posedge clk); #1;
      bus_if.host_ifu_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      reset_chk();
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("pend_drained", 64'(pend_q.size()), 64'd0);

      // Fetch after reset
      exp_q.push_back(64'hA5A5_0030_5A5A_FFCF);
      exp_q.push_back(64'hA5A5_0031_5A5A_FFCE);
      run(16'h0030, 1, 2, -1, 0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
